// File: rtl/axi4_lite_defs.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings and address decode.
// Used by both this responder and the mem stage master.
package axi4_lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // 33-bit compare keeps BASE + 4*DEPTH from wrapping at the top of the map
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + ({1'b0, 32'(depth)} << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/axi_lite_sram_bank.sv
// DEPTH x 32 data RAM: one byte-enabled write port, one registered read port.
// Reads return the word as it was before a same-edge write.
module axi_lite_sram_bank #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             re,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (re) rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder in front of a byte-strobed word RAM.
// Independent write (AW/W/B) and read (AR/R) paths, one outstanding transaction each.
module axi4_lite_slave_mem
  import axi4_lite_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rd_hit_q, rd_hit_d;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_hit, rd_hit;
  logic [31:0] ram_rdata;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign awready = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign wready  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign arready = (rd_state_q == RD_IDLE);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A channel that is not yet held can only be contributing via a live handshake
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q ? wdata_q : wdata;
  assign wr_strb = w_held_q ? wstrb_q : wstrb;
  assign wr_hit  = addr_hit(wr_addr, BASE_ADDR, MEM_DEPTH);
  assign rd_hit  = addr_hit(araddr, BASE_ADDR, MEM_DEPTH);
  assign commit  = (wr_state_q == WR_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  axi_lite_sram_bank #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .we      (commit && wr_hit),
    .wr_idx  (word_idx(wr_addr)),
    .wr_be   (wr_strb),
    .wr_data (wr_data),
    .re      (ar_hs && rd_hit),
    .rd_idx  (word_idx(araddr)),
    .rd_data (ram_rdata)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (commit) begin
          bvalid_d   = 1'b1;
          bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rd_hit_d   = rd_hit_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rvalid_d   = 1'b1;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rd_hit_d   = rd_hit;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rd_hit_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rresp  = rresp_q;
  // The RAM output register is unreset; a miss (or reset) forces zero instead
  assign rdata  = rd_hit_q ? ram_rdata : 32'h0;

  a_aw_stable: assert property (@(posedge clk) disable iff (rst)
    awvalid && !awready |=> awvalid && $stable(awaddr));
  a_w_stable: assert property (@(posedge clk) disable iff (rst)
    wvalid && !wready |=> wvalid && $stable(wdata) && $stable(wstrb));
  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    arvalid && !arready |=> arvalid && $stable(araddr));

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares each response as it is accepted.
module tb_axi4_lite_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_mem dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a response is accepted on the edge after a negedge with valid&&ready
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(bvalid), 32'h0);
        end else begin
          logic [1:0] eb;
          eb = exp_b.pop_front();
          $display("B   resp=%0h (exp %0h)", bresp, eb);
          check("bresp", 32'(bresp), 32'(eb));
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'(rvalid), 32'h0);
        end else begin
          rexp_t er;
          er = exp_r.pop_front();
          $display("R   data=%h resp=%0h (exp %h/%0h)", rdata, rresp, er.d, er.r);
          check("rdata", rdata, er.d);
          check("rresp", 32'(rresp), 32'(er.r));
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    bit aw_done = 0;
    bit w_done  = 0;
    bit a_hs;
    bit w_hs;
    exp_b.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 32'h0, 32'h1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit done = 0;
    bit hs;
    exp_r.push_back('{d: ed, r: er});
    araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 1'b0; done = 1; end
    end
    if (!done) begin
      check("read_handshake_timeout", 32'h0, 32'h1);
      arvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && c < 50) begin
      @(posedge clk);
      c++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_awready", 32'(awready), 32'h1);
    check("rst_wready",  32'(wready),  32'h1);
    check("rst_arready", 32'(arready), 32'h1);
    check("rst_bvalid",  32'(bvalid),  32'h0);
    check("rst_rvalid",  32'(rvalid),  32'h0);
    check("rst_bresp",   32'(bresp),   32'h0);
    check("rst_rresp",   32'(rresp),   32'h0);
    check("rst_rdata",   rdata,        32'h0);
    @(posedge clk); #1;

    // Aligned write then read, AW and W together
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    do_read(32'h10, 32'hDEADBEEF, 2'b00);
    do_read(32'h13, 32'hDEADBEEF, 2'b00);
    wait_idle();

    // W three cycles ahead of AW
    exp_b.push_back(2'b00);
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_first_no_bvalid", 32'(bvalid), 32'h0);
    end
    @(posedge clk); #1;
    awaddr = 32'h20; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("w_first_bvalid_same_edge", 32'(bvalid), 32'h1);
    @(posedge clk); #1;
    do_read(32'h20, 32'h11223344, 2'b00);

    // Byte strobes
    do_write(32'h30, 32'hAABBCCDD, 4'hF, 2'b00);
    do_write(32'h30, 32'h00000055, 4'b0001, 2'b00);
    do_read(32'h30, 32'hAABBCC55, 2'b00);
    do_write(32'h30, 32'hFFFFFFFF, 4'b0000, 2'b00);
    do_read(32'h30, 32'hAABBCC55, 2'b00);
    do_write(32'h30, 32'h12345678, 4'b1010, 2'b00);
    do_read(32'h30, 32'h12BB5655, 2'b00);

    // Address range boundaries
    do_write(32'h0, 32'h01020304, 4'hF, 2'b00);
    do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 2'b10);
    do_read(32'h0, 32'h01020304, 2'b00);
    do_read(32'h1000, 32'h0, 2'b10);
    do_write(32'hFFC, 32'hCAFEF00D, 4'hF, 2'b00);
    do_read(32'hFFC, 32'hCAFEF00D, 2'b00);
    do_read(32'hFFFF_FFFC, 32'h0, 2'b10);
    wait_idle();

    // Backpressure on B and R
    bready = 1'b0; rready = 1'b0;
    do_write(32'h40, 32'h0BADCAFE, 4'hF, 2'b00);
    do_read(32'h10, 32'hDEADBEEF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid",  32'(bvalid),  32'h1);
      check("bp_bresp",   32'(bresp),   32'h0);
      check("bp_rvalid",  32'(rvalid),  32'h1);
      check("bp_rdata",   rdata,        32'hDEADBEEF);
      check("bp_rresp",   32'(rresp),   32'h0);
      check("bp_awready", 32'(awready), 32'h0);
      check("bp_wready",  32'(wready),  32'h0);
      check("bp_arready", 32'(arready), 32'h0);
    end
    @(posedge clk); #1 bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1 bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    check("bp_bvalid_done", 32'(bvalid), 32'h0);
    check("bp_rvalid_done", 32'(rvalid), 32'h0);
    @(posedge clk); #1 bready = 1'b1; rready = 1'b1;
    do_read(32'h40, 32'h0BADCAFE, 2'b00);
    wait_idle();

    // Reset with an AW latched and no W
    awaddr = 32'h50; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("rm_aw_held", 32'(awready), 32'h0);
    rst = 1'b1;
    #1 check("rm_async_awready", 32'(awready), 32'h1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rm_no_bvalid", 32'(bvalid), 32'h0);
    end
    check("rm_awready", 32'(awready), 32'h1);
    check("rm_wready",  32'(wready),  32'h1);
    @(posedge clk); #1;
    do_read(32'h10, 32'hDEADBEEF, 2'b00);
    do_write(32'h50, 32'h5A5A5A5A, 4'hF, 2'b00);
    do_read(32'h50, 32'h5A5A5A5A, 2'b00);
    wait_idle();

    check("b_queue_drained", 32'(exp_b.size()), 32'h0);
    check("r_queue_drained", 32'(exp_r.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
